// File: rtl/pc_pkg.sv
// Shared constants and operation encoding for the program counter with return-address stack.
package pc_pkg;
  localparam int PC_W      = 16;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [2:0] {HOLD, INC, LOAD, CALL, RET, TAIL, STALL} pc_op_e;

  // Priority: stall > call&ret > ret > call > load > inc > hold.
  function automatic pc_op_e decode_op(input logic stall, input logic call, input logic ret,
                                       input logic load, input logic inc);
    if (stall)             return STALL;
    else if (call && ret)  return TAIL;
    else if (ret)          return RET;
    else if (call)         return CALL;
    else if (load)         return LOAD;
    else if (inc)          return INC;
    else                   return HOLD;
  endfunction
endpackage

// File: rtl/ras_lifo.sv
// Circular return-address stack: push wraps over the oldest entry when full,
// replace rewrites the top in place, top is read combinationally.
module ras_lifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;       // next free slot; when full it is also the oldest entry
  logic [PW-1:0] top_idx;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push)         mem[ptr]     <= data;
    else if (replace) mem[top_idx] <= data;
  end
endmodule

// File: rtl/pc_ras.sv
// Program counter with call/return support: operation decode, next-PC mux,
// PC register and sticky overflow/underflow flags around a ras_lifo.
module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = PC_W,
  parameter int DEPTH = RAS_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in,
  input  logic          load,
  input  logic          inc,
  input  logic          call,
  input  logic          ret,
  input  logic          stall,
  output logic [W-1:0]  out,
  output logic [CW-1:0] ras_count,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          overflow,
  output logic          underflow
);
  pc_op_e       op;
  logic [W-1:0] pc, pc_nxt, pc_inc, top;
  logic         push, pop, replace, ovf_set, unf_set;

  assign op     = decode_op(stall, call, ret, load, inc);
  assign pc_inc = pc + W'(1);
  assign out    = pc;

  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      INC:  pc_nxt = pc_inc;
      LOAD: pc_nxt = in;
      CALL: begin
        push    = 1'b1;
        ovf_set = ras_full;
        pc_nxt  = in;
      end
      // Tail call on an empty stack degenerates to a plain call.
      TAIL: begin
        push    = ras_empty;
        replace = !ras_empty;
        pc_nxt  = in;
      end
      RET: begin
        if (ras_empty) unf_set = 1'b1;
        else begin
          pop    = 1'b1;
          pc_nxt = top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  ras_lifo #(.W(W), .DEPTH(DEPTH)) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .data    (pc_inc),
    .top     (top),
    .count   (ras_count),
    .empty   (ras_empty),
    .full    (ras_full)
  );
endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras with hand-computed expectations (W=16, DEPTH=8).
module tb_pc_ras;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0, stall = 1'b0;
  logic [15:0] out;
  logic [3:0]  ras_count;
  logic        ras_empty, ras_full, overflow, underflow;

  int n_cmp = 0;
  int n_err = 0;

  pc_ras #(.W(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc), .call(call),
    .ret(ret), .stall(stall), .out(out), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic c, input logic t,
                      input logic l, input logic i, input logic [15:0] d);
    reset = r; stall = s; call = c; ret = t; load = l; inc = i; in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] e_out, input logic [3:0] e_cnt,
                           input logic e_emp, input logic e_full, input logic e_ovf,
                           input logic e_unf);
    chk({tag, ".out"},   32'(out),       32'(e_out));
    chk({tag, ".count"}, 32'(ras_count), 32'(e_cnt));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(e_emp));
    chk({tag, ".full"},  32'(ras_full),  32'(e_full));
    chk({tag, ".ovf"},   32'(overflow),  32'(e_ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(e_unf));
  endtask

  initial begin
    //         rst stl cal ret lod inc in
    step(1, 0, 0, 0, 0, 0, 16'd0);
    chk_state("reset", 16'd0, 4'd0, 1, 0, 0, 0);

    // Sequential advance and wrap
    step(0, 0, 0, 0, 0, 1, 16'd0); chk("inc1", 32'(out), 32'd1);
    step(0, 0, 0, 0, 0, 1, 16'd0); chk("inc2", 32'(out), 32'd2);
    step(0, 0, 0, 0, 0, 1, 16'd0); chk("inc3", 32'(out), 32'd3);
    step(0, 0, 0, 0, 1, 1, 16'hFFFF); chk("load_over_inc", 32'(out), 32'hFFFF);
    step(0, 0, 0, 0, 0, 1, 16'd0); chk("wrap", 32'(out), 32'd0);
    step(0, 0, 0, 0, 0, 0, 16'd9); chk("hold", 32'(out), 32'd0);

    // Nested call/return
    step(0, 0, 0, 0, 1, 0, 16'd5);
    step(0, 0, 1, 0, 1, 1, 16'd100); chk_state("call1", 16'd100, 4'd1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 16'd200); chk_state("call2", 16'd200, 4'd2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 16'd999); chk_state("ret1", 16'd101, 4'd1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 16'd0);   chk_state("ret2", 16'd6, 4'd0, 1, 0, 0, 0);

    // Overflow: 9 calls from PC=0, return addresses 1,11,...,81; oldest (1) is lost
    step(1, 0, 0, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 9; k++) step(0, 0, 1, 0, 0, 0, 16'(10 * k));
    chk_state("full", 16'd90, 4'd8, 0, 1, 1, 0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 1, 0, 0, 16'd0);
      chk($sformatf("lifo%0d", j), 32'(out), 32'(10 * (8 - j) + 1));
    end
    chk_state("drained", 16'd11, 4'd0, 1, 0, 1, 0);

    // Underflow is sticky; PC holds on empty ret
    step(0, 0, 0, 1, 0, 0, 16'd0); chk_state("underflow", 16'd11, 4'd0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 16'd0); chk_state("inc_after_unf", 16'd12, 4'd0, 1, 0, 1, 1);

    // Tail call, stall
    step(1, 0, 0, 0, 0, 0, 16'd0);
    step(0, 0, 0, 0, 1, 0, 16'd6);
    step(0, 0, 1, 0, 0, 0, 16'd40);  chk_state("pre_tail", 16'd40, 4'd1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 16'd300); chk_state("tail", 16'd300, 4'd1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 16'd500); chk_state("stall_call", 16'd300, 4'd1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 16'd501); chk_state("stall_ret", 16'd300, 4'd1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 16'd0);   chk_state("ret_tail", 16'd41, 4'd0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 16'd77);  chk_state("tail_empty", 16'd77, 4'd1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 16'd0);   chk_state("ret_tail_empty", 16'd42, 4'd0, 1, 0, 0, 0);

    // Reset during call with count=3, plus stall asserted
    step(0, 0, 1, 0, 0, 0, 16'd50);
    step(0, 0, 1, 0, 0, 0, 16'd60);
    step(0, 0, 1, 0, 0, 0, 16'd70); chk("count3", 32'(ras_count), 32'd3);
    step(1, 1, 1, 0, 0, 0, 16'd80); chk_state("reset_mid", 16'd0, 4'd0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 16'd0);  chk_state("ret_after_reset", 16'd0, 4'd0, 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 Parameter W, default 16: PC and return-address width in bits.
REQ-002 Parameter DEPTH, default 8: return-address-stack entries, power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in  input  W  jump/call target address.
REQ-006 load  input  1  jump: PC <= in.
REQ-007 inc  input  1  sequential advance: PC <= PC+1.
REQ-008 call  input  1  push PC+1 onto the stack; PC <= in.
REQ-009 ret  input  1  pop the stack top into PC.
REQ-010 stall  input  1  freeze PC and stack for this cycle.
REQ-011 out  output  W  current PC, driven directly from the register with no combinational path from inputs.
REQ-012 ras_count  output  clog2(DEPTH)+1  number of valid stack entries.
REQ-013 ras_empty / ras_full  output  1 each  ras_count==0 / ras_count==DEPTH.
REQ-014 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-015 Per-cycle priority: reset > stall > (call&ret) > ret > call > load > inc > hold.
REQ-016 stall: PC, stack contents, ras_count and flags all hold, regardless of other inputs.
REQ-017 inc: PC <= PC+1, modulo 2^W; all-ones wraps to 0.
REQ-018 load: PC <= in; stack unchanged.
REQ-019 call when not full: push PC+1 (mod 2^W), ras_count+1, PC <= in; new out and ras_count are visible the cycle after the edge.
REQ-020 call when full: stack acts circularly; the oldest entry is overwritten, ras_count stays at DEPTH, PC <= in, and overflow sets.
REQ-021 ret when not empty: PC <= top entry, ras_count-1.
REQ-022 ret when empty: PC holds, ras_count stays 0, and underflow sets.
REQ-023 call&ret together (tail call): top entry replaced with PC+1, ras_count unchanged, PC <= in; if empty, behaves exactly as call.
REQ-024 load and inc are ignored whenever call or ret is asserted.
REQ-025 overflow and underflow stay set until reset; no other event clears them.
REQ-026 After 1..DEPTH pushes without overflow, pops return addresses in exact LIFO order.
REQ-027 Stack read of the top entry is combinational into the next-PC mux; single-cycle ret latency, no bubbles.

Reset
REQ-028 reset gives out=0, ras_count=0, ras_empty=1, ras_full=0, overflow=0, underflow=0 on the next edge.
REQ-029 reset mid-operation, including together with call/ret/stall, discards all stack contents; entry RAM need not be cleared, only the pointer and count.
REQ-030 No output is X after the first reset edge.

Structure
REQ-031 Shared package pc_pkg holds the default W and DEPTH constants and the priority-encoded operation enum (HOLD, INC, LOAD, CALL, RET, TAIL, STALL).
REQ-032 One sub-module, ras_lifo (parameters W, DEPTH): circular storage, top pointer, count, push/pop/replace ports.
REQ-033 pc_ras contains only the operation decode, next-PC mux, PC register and sticky flags.

Verification
REQ-034 Reset, then inc for 3 cycles -> out 0,1,2,3; set PC=16'hFFFF via load, then inc -> out=0.
REQ-035 PC=5, call in=100; PC=100, call in=200 -> out=200, count=2; ret -> out=101, count=1; ret -> out=6, count=0, empty=1.
REQ-036 DEPTH=8: 9 calls from PC=0 with in=10*k -> count=8, full=1, overflow=1; then 8 rets return the 8 newest return addresses in order and count=0.
REQ-037 ret at count=0 -> out unchanged, underflow=1; subsequent inc works normally and underflow stays 1 until reset.
REQ-038 PC=40, count=1, top=7, call&ret in=300 -> out=300, count=1, top=41; call with stall=1 -> no change in out, count or flags.
REQ-039 reset asserted during call with count=3 -> out=0, count=0, flags 0; next ret -> underflow=1.
